// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, ShiftRows and MixColumns.
// Byte i of a block sits at blk[i*8 +: 8] on a [0:127] vector (byte 0 = MSB end),
// column-major: byte r+4c is row r, column c.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam logic [7:0]  GF_POLY     = 8'h1b;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // Row r is rotated left by r byte positions.
    function automatic logic [0:AES_BLOCK_W-1] shift_rows(input logic [0:AES_BLOCK_W-1] s);
        logic [0:AES_BLOCK_W-1] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[(rr + 4 * c) * 8 +: 8] = s[(rr + 4 * ((c + rr) & 3)) * 8 +: 8];
            end
        end
        return r;
    endfunction

    // One column; a0 is the row-0 byte, held in the top byte of col.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [0:AES_BLOCK_W-1] mix_columns(input logic [0:AES_BLOCK_W-1] s);
        logic [0:AES_BLOCK_W-1] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[c * 32 +: 32] = mix_column(s[c * 32 +: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_stage_fifo.sv
// Generic valid/ready FIFO. Output is taken from registered storage only and
// in_ready depends only on the occupancy register. DEPTH must be a power of two >= 2.
module aes_stage_fifo #(
    parameter int unsigned WIDTH = 132,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_last;

    logic w_push;
    logic w_pop;

    assign in_ready  = (r_count != CNT_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    // When empty, keep presenting the most recently popped head.
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : r_last;

    // Storage array; contents are only observable through a nonzero count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: unchanged on simultaneous push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Capture the head as it leaves so out_data holds once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= r_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/aes_round_tail.sv
// Tail of an AES-128 encrypt round: ShiftRows, MixColumns (bypassed on the
// final round) and AddRoundKey, with the result queued in a small output FIFO.
module aes_round_tail
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:AES_BLOCK_W-1] in_state,
    input  logic [0:AES_BLOCK_W-1] in_key,
    input  logic                   in_last,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:AES_BLOCK_W-1] out_state,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int unsigned ENTRY_W = TAG_W + AES_BLOCK_W;

    logic [0:AES_BLOCK_W-1] w_shift;
    logic [0:AES_BLOCK_W-1] w_mix;
    logic [0:AES_BLOCK_W-1] w_result;
    logic [ENTRY_W-1:0]     w_fifo_in;
    logic [ENTRY_W-1:0]     w_fifo_out;

    // Combinational round function.
    always_comb begin
        w_shift  = shift_rows(in_state);
        w_mix    = mix_columns(w_shift);
        w_result = (in_last ? w_shift : w_mix) ^ in_key;
    end

    // Byte 0 lands in the top bits of the state field, so the slice back out is order-preserving.
    assign w_fifo_in = {in_tag, w_result};
    assign out_state = w_fifo_out[AES_BLOCK_W-1:0];
    assign out_tag   = w_fifo_out[ENTRY_W-1:AES_BLOCK_W];

    aes_stage_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_fifo_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_fifo_out)
    );

endmodule
